// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: merges the pipeline writeback with a multi-cycle unit result via a one-entry hold buffer.
// Optional force_count statistics output is enabled by defining WB_ARB_STATS_EN.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mc_valid,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    output logic        mc_ready,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef WB_ARB_STATS_EN
    output logic [15:0] force_count,
`endif
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_starve;
    logic [2:0]  w_starve_next;
    logic [2:0]  w_starve_inc;
    logic [4:0]  r_buf_addr;
    logic [31:0] r_buf_data;
    logic        w_pipe_live;
    logic        w_mc_fire;
    logic        w_cap;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    // mc handshake: a result transfers on any rising edge where mc_valid && mc_ready;
    // mc_ready depends only on state, never on mc_valid.
    assign mc_ready     = (r_state == EMPTY);
    assign pipe_stall   = (r_state == FORCE);
    assign o_dbg_state  = r_state;
    assign w_pipe_live  = pipe_we && (pipe_waddr != 5'd0);
    assign w_mc_fire    = mc_valid && mc_ready;
    assign w_starve_inc = r_starve + 3'd1;

    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve;
        w_cap         = 1'b0;
        w_we          = 1'b0;
        w_waddr       = pipe_waddr;
        w_wdata       = pipe_wdata;
        case (r_state)
            EMPTY: begin
                w_starve_next = 3'd0;
                if (w_pipe_live) begin
                    w_we = 1'b1;
                    if (w_mc_fire && (mc_waddr != 5'd0)) begin
                        w_cap        = 1'b1;
                        w_state_next = HELD;
                    end
                end else if (w_mc_fire && (mc_waddr != 5'd0)) begin
                    w_we    = 1'b1;
                    w_waddr = mc_waddr;
                    w_wdata = mc_wdata;
                end
            end
            HELD: begin
                if (w_pipe_live) begin
                    w_we = 1'b1;
                    if (pipe_waddr == r_buf_addr) begin
                        // Younger pipeline write to the same register makes the buffer stale.
                        w_state_next  = EMPTY;
                        w_starve_next = 3'd0;
                    end else begin
                        w_starve_next = w_starve_inc;
                        if (w_starve_inc == LP_LIMIT)
                            w_state_next = FORCE;
                    end
                end else begin
                    w_we          = 1'b1;
                    w_waddr       = r_buf_addr;
                    w_wdata       = r_buf_data;
                    w_state_next  = EMPTY;
                    w_starve_next = 3'd0;
                end
            end
            FORCE: begin
                w_we          = 1'b1;
                w_state_next  = EMPTY;
                w_starve_next = 3'd0;
                if (!(w_pipe_live && (pipe_waddr == r_buf_addr))) begin
                    w_waddr = r_buf_addr;
                    w_wdata = r_buf_data;
                end
            end
            default: begin
                w_state_next  = EMPTY;
                w_starve_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_starve   <= 3'd0;
            r_buf_addr <= 5'd0;
            r_buf_data <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
            if (w_cap) begin
                r_buf_addr <= mc_waddr;
                r_buf_data <= mc_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= w_we;
            if (w_we) begin
                rf_waddr <= w_waddr;
                rf_wdata <= w_wdata;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_force_count;
    assign force_count = r_force_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_force_count <= 16'd0;
        else if ((w_state_next == FORCE) && (r_state != FORCE) && (r_force_count != 16'hFFFF))
            r_force_count <= r_force_count + 16'd1;
    end
`endif

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive lost cycles (1..7) before a forced multi-cycle write.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port pipe_we, input, 1, writeback-stage register write enable (RegWrite_out after MEM/WB).
REQ-005 The block SHALL have port pipe_waddr, input, 5, writeback-stage destination register.
REQ-006 The block SHALL have port pipe_wdata, input, 32, writeback-stage data (already MemtoReg-muxed).
REQ-007 The block SHALL have port mc_valid, input, 1, multi-cycle unit (mul/div) result valid.
REQ-008 The block SHALL have port mc_waddr, input, 5, multi-cycle result destination.
REQ-009 The block SHALL have port mc_wdata, input, 32, multi-cycle result data.
REQ-010 The block SHALL have port mc_ready, output, 1, hold buffer empty; result accepted when mc_valid && mc_ready.
REQ-011 The block SHALL have port pipe_stall, output, 1, request to hold MEM/WB for the current cycle.
REQ-012 The block SHALL have ports rf_we (1), rf_waddr (5), rf_wdata (32), outputs, registered register-file write port.

Function
REQ-013 The FSM SHALL have states EMPTY, HELD, FORCE; mc_ready = (state==EMPTY); pipe_stall = (state==FORCE), both decoded from state only.
REQ-014 A pipeline write is "live" iff pipe_we=1 and pipe_waddr!=0; writes to r0 SHALL never reach rf_we.
REQ-015 EMPTY: live pipeline write SHALL win; an accepted mc result SHALL be written directly if no live pipeline write, else captured into the hold buffer and state -> HELD.
REQ-016 HELD: no live pipeline write -> buffer written, state -> EMPTY; live pipeline write -> pipeline written, starve counter +1.
REQ-017 HELD: when the starve counter reaches STARVE_LIMIT, state SHALL -> FORCE on the next edge.
REQ-018 FORCE (exactly one cycle): buffer SHALL be written, pipeline input ignored (it is being held), state -> EMPTY, counter cleared.
REQ-019 HELD/FORCE with live pipeline write to the buffered address: buffer SHALL be discarded (younger pipeline write supersedes), pipeline written, state -> EMPTY.
REQ-020 Buffered mc_waddr==0 SHALL be discarded on capture (mc_ready stays 1, no write).
REQ-021 rf_we/rf_waddr/rf_wdata SHALL appear exactly 1 cycle after the arbitration cycle; rf_we=0 cycles keep prior addr/data.
REQ-022 At most one register-file write SHALL occur per cycle; no accepted result SHALL be lost except per REQ-019/020.

Reset
REQ-023 reset=0 SHALL asynchronously force state EMPTY, counter 0, buffer invalid, rf_we=0, rf_waddr=0, rf_wdata=0, mc_ready=1, pipe_stall=0.
REQ-024 A buffered result present at reset assertion SHALL be dropped; operation resumes on the first rising clk after reset=1.

Configuration
REQ-025 Macro WB_ARB_STATS_EN defined: add output force_count (16-bit), incremented on each FORCE entry, saturating at 0xFFFF, reset to 0.
REQ-026 Macro WB_ARB_STATS_EN undefined: force_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Pipe-only: pipe_we=1, waddr=5, wdata=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; mc_ready stays 1.
REQ-028 Idle mc: mc_valid=1, waddr=7, data=0xAAAA, pipe_we=0 -> next cycle rf write r7=0xAAAA, no HELD entry.
REQ-029 Conflict: mc r7=0xBEEF with pipe r3 same cycle -> r3 written, mc_ready=0; pipe_we=0 next cycle -> r7=0xBEEF written, mc_ready=1.
REQ-030 Starvation (STARVE_LIMIT=4): HELD r9 plus 4 live pipe writes -> pipe_stall=1 for exactly one cycle, r9 written, then EMPTY.
REQ-031 Supersede: HELD r9=0x1, pipe writes r9=0x2 -> rf r9=0x2 only, buffer dropped, mc_ready=1 next cycle.
REQ-032 Reset mid-HELD: reset=0 asynchronously -> rf_we=0, mc_ready=1, pipe_stall=0 without clk edge; buffered value never written.
